// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, registered-result RV32-style ALU with an optional
// iterative M-extension unit (shift-add multiply, restoring divide).
// Base ops finish in one cycle; M ops take WIDTH+1 cycles from accept.
module alu_pipe #(
   parameter int WIDTH     = 32,
   parameter bit MULDIV_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_AND   = 5'd2;
   localparam logic [4:0] OP_OR    = 5'd3;
   localparam logic [4:0] OP_XOR   = 5'd4;
   localparam logic [4:0] OP_SLT   = 5'd5;
   localparam logic [4:0] OP_SLTU  = 5'd6;
   localparam logic [4:0] OP_SLL   = 5'd7;
   localparam logic [4:0] OP_SRL   = 5'd8;
   localparam logic [4:0] OP_SRA   = 5'd9;
   localparam logic [4:0] OP_COPY1 = 5'd10;
   localparam logic [4:0] OP_MUL   = 5'd11;
   localparam logic [4:0] OP_MULH  = 5'd12;
   localparam logic [4:0] OP_MULHU = 5'd13;
   localparam logic [4:0] OP_DIV   = 5'd14;
   localparam logic [4:0] OP_DIVU  = 5'd15;
   localparam logic [4:0] OP_REM   = 5'd16;
   localparam logic [4:0] OP_REMU  = 5'd17;

   logic [0:0]         state;
   logic               live;        // low until the first edge after reset release
   logic [SHW-1:0]     cnt;
   logic [4:0]         op_r;
   logic [WIDTH-1:0]   dvs;         // multiplicand / divisor magnitude
   logic [2*WIDTH-1:0] acc;         // {hi, lo}: product, or {remainder, dividend->quotient}
   logic               neg_q, neg_r, b_zero;

   logic               accept, is_md, out_free, last, finish, step;
   logic               sgn_op, s1, s2;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [SHW-1:0]     shamt;
   logic [WIDTH-1:0]   base_res, md_res;
   logic [2*WIDTH-1:0] acc_n;

   assign out_free = !out_valid || out_ready;
   assign in_ready = live && (state == S_IDLE) && out_free;
   assign accept   = in_valid && in_ready;
   assign is_md    = MULDIV_EN && (op >= OP_MUL) && (op <= OP_REMU);
   assign busy     = (state == S_BUSY);
   assign last     = busy && (cnt == LAST);
   // The final iteration loads the result, so it waits for a free output slot.
   assign finish   = last && out_free;
   assign step     = busy && (!last || out_free);
   assign shamt    = op2[SHW-1:0];

   // Signed M ops iterate on magnitudes; signs are reapplied at the end.
   assign sgn_op = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   assign s1     = sgn_op && op1[WIDTH-1];
   assign s2     = sgn_op && op2[WIDTH-1];
   assign mag1   = s1 ? -op1 : op1;
   assign mag2   = s2 ? -op2 : op2;

   // Single-cycle base ALU; reserved encodings yield zero.
   always_comb begin
      base_res = '0;
      case (op)
         OP_ADD:   base_res = op1 + op2;
         OP_SUB:   base_res = op1 - op2;
         OP_AND:   base_res = op1 & op2;
         OP_OR:    base_res = op1 | op2;
         OP_XOR:   base_res = op1 ^ op2;
         OP_SLT:   base_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
         OP_SLTU:  base_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
         OP_SLL:   base_res = op1 << shamt;
         OP_SRL:   base_res = op1 >> shamt;
         OP_SRA:   base_res = $signed(op1) >>> shamt;
         OP_COPY1: base_res = op1;
         default:  base_res = '0;
      endcase
   end

   // One multiply or divide iteration on the shared accumulator.
   always_comb begin
      logic [WIDTH-1:0] addend;
      logic [WIDTH:0]   msum, shf, dif;
      logic             ge;
      logic [WIDTH-1:0] rem_n;
      addend = acc[0] ? dvs : '0;
      msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      shf    = acc[2*WIDTH-1:WIDTH-1];
      ge     = (shf >= {1'b0, dvs});
      dif    = shf - {1'b0, dvs};
      rem_n  = ge ? dif[WIDTH-1:0] : shf[WIDTH-1:0];
      if (op_r <= OP_MULHU)
         acc_n = {msum, acc[WIDTH-1:1]};
      else
         acc_n = {rem_n, acc[WIDTH-2:0], ge};
   end

   // Sign correction and special cases applied to the final iteration's value.
   always_comb begin
      logic [2*WIDTH-1:0] prod;
      logic [WIDTH-1:0]   q, r;
      prod   = neg_q ? -acc_n : acc_n;
      q      = acc_n[WIDTH-1:0];
      r      = acc_n[2*WIDTH-1:WIDTH];
      md_res = '0;
      case (op_r)
         OP_MUL:            md_res = prod[WIDTH-1:0];
         OP_MULH, OP_MULHU: md_res = prod[2*WIDTH-1:WIDTH];
         OP_DIV:            md_res = b_zero ? '1 : (neg_q ? -q : q);
         OP_DIVU:           md_res = b_zero ? '1 : q;
         OP_REM:            md_res = neg_r ? -r : r;
         OP_REMU:           md_res = r;
         default:           md_res = '0;
      endcase
   end

   // Hold in_ready low for the first edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) live <= 1'b0;
      else      live <= 1'b1;
   end

   // Control FSM and iterative datapath state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         op_r   <= '0;
         dvs    <= '0;
         acc    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
      end else if (state == S_IDLE) begin
         if (accept && is_md) begin
            state  <= S_BUSY;
            cnt    <= '0;
            op_r   <= op;
            dvs    <= mag2;
            acc    <= {{WIDTH{1'b0}}, mag1};
            neg_q  <= s1 ^ s2;
            neg_r  <= s1;
            b_zero <= (op2 == '0);
         end
      end else if (step) begin
         acc <= acc_n;
         cnt <= cnt + SHW'(1);
         if (last) state <= S_IDLE;
      end
   end

   // Output register: load on base accept or M completion, clear on consume.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         result    <= '0;
      end else if (accept && !is_md) begin
         out_valid <= 1'b1;
         result    <= base_res;
      end else if (finish) begin
         out_valid <= 1'b1;
         result    <= md_res;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle RV32 ALU.
- Width is configurable (WIDTH). The result is registered. An optional iterative multiply/divide unit implements the RISC-V M-extension ops.
- Sits between the decode/operand-read stage and writeback. Uses valid/ready on both sides so it can stall the pipeline during multi-cycle ops.

Parameters:
WIDTH, 32, operand/result width in bits; power of two, >= 8
MULDIV_EN, 1, 1 = M-extension ops implemented; 0 = ops 11..17 treated as reserved
SHW, log2(WIDTH), derived shift-amount width; not overridable

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
op  in  5  operation select (encoding below)
op1  in  WIDTH  operand 1
op2  in  WIDTH  operand 2
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
result  out  WIDTH  registered result
busy  out  1  high while the iterative unit is running

Behaviour:
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 COPY1 (result = op1).
  - 11 MUL (low WIDTH bits), 12 MULH (signed x signed, high half), 13 MULHU (unsigned, high half).
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - 18..31 reserved: result = 0, single-cycle latency. Ops 11..17 are also reserved when MULDIV_EN = 0.
- Shift amount = op2[SHW-1:0]; upper op2 bits ignored.
- SLT/SLTU: result is zero-extended 1/0.
- ADD/SUB wrap modulo 2^WIDTH; no carry or overflow outputs.
- Reset (rst = 0, async):
  - FSM -> IDLE; out_valid = 0, result = 0, busy = 0.
  - in_ready goes to 1 once rst = 1 and output is empty.
  - Reset mid-operation discards the in-flight op; no result is produced.
- FSM states:
  - IDLE: accepts a request if in_ready.
    - Base/reserved op -> result register loaded, out_valid = 1 next cycle; stay IDLE.
    - M op -> capture operands, go to BUSY, counter = 0.
  - BUSY:
    - One iteration per cycle: shift-add multiply or restoring divide, operating on magnitudes for the signed ops.
    - After WIDTH iterations (counter = WIDTH-1): apply sign correction, load result, out_valid = 1, -> IDLE.
    - busy = 1 throughout BUSY.
- in_ready = (state == IDLE) && (!out_valid || out_ready). Back-to-back base ops sustain one per cycle while out_ready = 1.
- Latency from the accept edge to out_valid:
  - base ops: 1 cycle
  - M ops: WIDTH+1 cycles, fixed, including special cases
- Output hold: while out_valid && !out_ready, result and out_valid are held stable, and in_ready = 0.
- A BUSY op that completes while the output is still occupied stalls in BUSY at its final iteration until the output is free. No result is ever overwritten.
- Operands and op are captured at accept; input changes afterwards have no effect.
- Divide special cases (RISC-V rules):
  - divisor 0: DIV/DIVU = all ones; REM/REMU = op1.
  - signed overflow (op1 = -2^(WIDTH-1), op2 = -1): DIV = op1; REM = 0.
- Remainder takes the sign of the dividend; quotient truncates toward zero.
- MULH: sign = op1[MSB] ^ op2[MSB]; the 2*WIDTH product is negated before the high half is taken.

Test Plan:
- Reset: hold rst = 0 with random inputs -> out_valid = 0, result = 0, busy = 0. Release -> in_ready = 1 on the next cycle.
- Base ops, WIDTH = 32, out_ready = 1, back-to-back:
  - ADD 0xFFFFFFFF+1 -> 0
  - SUB 0-1 -> 0xFFFFFFFF
  - SLT 0x80000000<1 -> 1
  - SLTU same operands -> 0
  - SRA 0x80000000 by op2 = 0x21 -> 0xC0000000 (shamt = 1)
  - Each result appears 1 cycle after accept, one per cycle.
- M ops:
  - MUL 0xFFFFFFFF*0xFFFFFFFF -> 1
  - MULHU same operands -> 0xFFFFFFFE
  - MULH -1*-1 -> 0
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF
  - out_valid exactly 33 cycles after accept; busy high for 32 cycles; in_ready = 0 throughout.
- Special divide cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0
- Backpressure: hold out_ready = 0 after an ADD result -> result stable, in_ready = 0, a pending in_valid is not accepted. Issue a DIVU while the output is full: it is not accepted until out_ready pulses. Nothing is lost or duplicated.
- Reset mid-BUSY: assert rst at iteration 10 of a DIV -> busy and out_valid drop immediately; no result after release. The next ADD completes normally. Repeat with WIDTH = 8, MULDIV_EN = 0: op 11 -> result 0 after 1 cycle.
